// File: rtl/systolic_gemm_tile.sv
// systolic_gemm_tile: output-stationary ARR_HEIGHT x ARR_WIDTH MAC array.
// Upstream feeds unskewed A-column / B-row vectors. The block skews them
// internally, runs a K-length job, flushes the wavefront, and then drains
// the C rows one at a time through a valid/ready handshake.
// Optional build macro SA_SATURATE_EN: when it is defined, each accumulate
// saturates to the signed or unsigned ACC_W range instead of wrapping.
module systolic_gemm_tile #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int ACC_W      = 40,
    parameter int K_MAX      = 256,
    localparam int KW        = $clog2(K_MAX + 1),
    localparam int IDX_W     = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       signed_mode,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0] in_a,
    input  logic [ARR_WIDTH*WIDTH-1:0] in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ARR_WIDTH*ACC_W-1:0] out_row,
    output logic [IDX_W-1:0]           out_row_idx,
    output logic                       out_last
);

    localparam int FW         = $clog2(ARR_HEIGHT + ARR_WIDTH);
    localparam int FLUSH_LAST = ARR_HEIGHT + ARR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_len_reg;
    logic [KW-1:0]   k_cnt_reg;
    logic [FW-1:0]   f_cnt_reg;
    logic            mode_reg;
    logic [KW-1:0]   k_eff;
    logic            step;
    logic            clear;
    logic            loading;

    // Skewed operands entering the west and north edges of the grid.
    logic [WIDTH-1:0] a_edge [ARR_HEIGHT];
    logic [WIDTH-1:0] b_edge [ARR_WIDTH];
    // Operands that each PE forwards to its east and south neighbours.
    logic [WIDTH-1:0] a_pipe [ARR_HEIGHT][ARR_WIDTH];
    logic [WIDTH-1:0] b_pipe [ARR_HEIGHT][ARR_WIDTH];
    logic [ACC_W-1:0] acc_arr [ARR_HEIGHT][ARR_WIDTH];

    assign k_eff   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign loading = (state_reg == LOAD);
    // The whole array advances together: on each accepted vector in LOAD,
    // and on every cycle of FLUSH.
    assign step    = (loading && in_valid) || (state_reg == FLUSH);
    // An accepted start wipes all datapath state so no earlier job leaks in.
    assign clear   = (state_reg == IDLE) && start;

    // Job control FSM. All handshake and status outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            k_len_reg   <= '0;
            k_cnt_reg   <= '0;
            f_cnt_reg   <= '0;
            mode_reg    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        k_len_reg <= k_eff;
                        mode_reg  <= signed_mode;
                        k_cnt_reg <= '0;
                        busy      <= 1'b1;
                        if (k_eff == '0) begin
                            state_reg   <= DRAIN;
                            out_valid   <= 1'b1;
                            out_row_idx <= '0;
                            out_last    <= (ARR_HEIGHT == 1);
                        end else begin
                            state_reg <= LOAD;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        k_cnt_reg <= k_cnt_reg + KW'(1);
                        if (k_cnt_reg == k_len_reg - KW'(1)) begin
                            state_reg <= FLUSH;
                            in_ready  <= 1'b0;
                            f_cnt_reg <= '0;
                        end
                    end
                end
                FLUSH: begin
                    f_cnt_reg <= f_cnt_reg + FW'(1);
                    if (f_cnt_reg == FW'(FLUSH_LAST)) begin
                        state_reg   <= DRAIN;
                        out_valid   <= 1'b1;
                        out_row_idx <= '0;
                        out_last    <= (ARR_HEIGHT == 1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_row_idx == IDX_W'(ARR_HEIGHT - 1)) begin
                            state_reg   <= DONE;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_row_idx <= '0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            out_row_idx <= out_row_idx + IDX_W'(1);
                            out_last    <= ((out_row_idx + IDX_W'(1)) == IDX_W'(ARR_HEIGHT - 1));
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    genvar gi, gj;

    // Row skew: row gi sees its A lane delayed by gi steps. Zeros enter outside LOAD.
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_skew
        logic [WIDTH-1:0] a_src;
        assign a_src = loading ? in_a[gi*WIDTH +: WIDTH] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_src;
        end else begin : g_delay
            logic [WIDTH-1:0] dly_reg [gi];
            // Shift line of depth gi, advancing only on array steps.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < gi; d++) dly_reg[d] <= '0;
                end else if (clear) begin
                    for (int d = 0; d < gi; d++) dly_reg[d] <= '0;
                end else if (step) begin
                    dly_reg[0] <= a_src;
                    for (int d = 1; d < gi; d++) dly_reg[d] <= dly_reg[d-1];
                end
            end
            assign a_edge[gi] = dly_reg[gi-1];
        end
    end

    // Column skew: column gi sees its B lane delayed by gi steps.
    for (gi = 0; gi < ARR_WIDTH; gi++) begin : g_b_skew
        logic [WIDTH-1:0] b_src;
        assign b_src = loading ? in_b[gi*WIDTH +: WIDTH] : '0;
        if (gi == 0) begin : g_direct
            assign b_edge[gi] = b_src;
        end else begin : g_delay
            logic [WIDTH-1:0] dly_reg [gi];
            // Shift line of depth gi, advancing only on array steps.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < gi; d++) dly_reg[d] <= '0;
                end else if (clear) begin
                    for (int d = 0; d < gi; d++) dly_reg[d] <= '0;
                end else if (step) begin
                    dly_reg[0] <= b_src;
                    for (int d = 1; d < gi; d++) dly_reg[d] <= dly_reg[d-1];
                end
            end
            assign b_edge[gi] = dly_reg[gi-1];
        end
    end

    // Processing elements: A moves east, B moves south, C stays in place.
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : g_row
        for (gj = 0; gj < ARR_WIDTH; gj++) begin : g_pe
            logic [WIDTH-1:0]          a_in;
            logic [WIDTH-1:0]          b_in;
            logic [WIDTH-1:0]          a_reg;
            logic [WIDTH-1:0]          b_reg;
            logic [ACC_W-1:0]          acc_reg;
            logic [ACC_W-1:0]          acc_next;
            logic signed [2*WIDTH-1:0] prod_s;
            logic [2*WIDTH-1:0]        prod_u;
            logic [ACC_W-1:0]          prod_ext;

            if (gj == 0) begin : g_a_west
                assign a_in = a_edge[gi];
            end else begin : g_a_nbr
                assign a_in = a_pipe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_north
                assign b_in = b_edge[gj];
            end else begin : g_b_nbr
                assign b_in = b_pipe[gi-1][gj];
            end

            assign prod_s   = (2*WIDTH)'($signed(a_in)) * (2*WIDTH)'($signed(b_in));
            assign prod_u   = (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
            assign prod_ext = mode_reg ? ACC_W'(prod_s) : ACC_W'(prod_u);

`ifdef SA_SATURATE_EN
            logic [ACC_W:0] sum_wide;
            assign sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};
            // Clamp at the signed or unsigned range edge instead of wrapping.
            always_comb begin
                acc_next = sum_wide[ACC_W-1:0];
                if (mode_reg) begin
                    if ((acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                        (sum_wide[ACC_W-1] != acc_reg[ACC_W-1])) begin
                        acc_next = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                    : {1'b0, {(ACC_W-1){1'b1}}};
                    end
                end else if (sum_wide[ACC_W]) begin
                    acc_next = '1;
                end
            end
`else
            assign acc_next = acc_reg + prod_ext;
`endif

            // PE state moves only on array steps and is wiped when a job starts.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_reg   <= '0;
                    b_reg   <= '0;
                    acc_reg <= '0;
                end else if (clear) begin
                    a_reg   <= '0;
                    b_reg   <= '0;
                    acc_reg <= '0;
                end else if (step) begin
                    a_reg   <= a_in;
                    b_reg   <= b_in;
                    acc_reg <= acc_next;
                end
            end

            assign a_pipe[gi][gj]  = a_reg;
            assign b_pipe[gi][gj]  = b_reg;
            assign acc_arr[gi][gj] = acc_reg;
        end
    end

    // Row-serial result mux. Outside DRAIN it reads as zero, and during a
    // stall it holds because the accumulators do not step in DRAIN.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int j = 0; j < ARR_WIDTH; j++) begin
                out_row[j*ACC_W +: ACC_W] = acc_arr[out_row_idx][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// tb_systolic_gemm_tile: randomized and directed jobs for systolic_gemm_tile,
// checked against a plain matrix-product reference model.
module tb_systolic_gemm_tile;

    localparam int DW   = 16;
    localparam int H    = 4;
    localparam int W    = 4;
    localparam int AW   = 40;
    localparam int KMAX = 256;
    localparam int KW   = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            signed_mode = 1'b0;
    logic            busy;
    logic            done;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [H*DW-1:0] in_a = '0;
    logic [W*DW-1:0] in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W*AW-1:0] out_row;
    logic [1:0]      out_row_idx;
    logic            out_last;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] a_mat [320][H];
    logic [DW-1:0] b_mat [320][W];
    logic [AW-1:0] exp_c [H][W];

    systolic_gemm_tile dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: C[i][j] = sum_k A[k][i]*B[k][j], extended per mode.
    function automatic logic [AW-1:0] model_c(input int i, input int j, input int keff, input bit mode);
        longint acc;
        longint p;
        longint max_s;
        longint min_s;
        longint max_u;
        max_s = (64'sd1 <<< (AW-1)) - 1;
        min_s = -(64'sd1 <<< (AW-1));
        max_u = (64'sd1 <<< AW) - 1;
        acc = 0;
        for (int k = 0; k < keff; k++) begin
            if (mode) p = longint'($signed(a_mat[k][i])) * longint'($signed(b_mat[k][j]));
            else      p = longint'(a_mat[k][i]) * longint'(b_mat[k][j]);
            acc = acc + p;
`ifdef SA_SATURATE_EN
            if (mode) begin
                if (acc > max_s) acc = max_s;
                if (acc < min_s) acc = min_s;
            end else if (acc > max_u) begin
                acc = max_u;
            end
`endif
        end
        return acc[AW-1:0];
    endfunction

    task automatic fill_identity();
        for (int k = 0; k < 320; k++) begin
            for (int i = 0; i < H; i++) a_mat[k][i] = (i == k) ? 16'd1 : 16'd0;
            for (int j = 0; j < W; j++) b_mat[k][j] = 16'(4*k + j + 1);
        end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int k = 0; k < 320; k++) begin
            for (int i = 0; i < H; i++) a_mat[k][i] = av;
            for (int j = 0; j < W; j++) b_mat[k][j] = bv;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 320; k++) begin
            for (int i = 0; i < H; i++) a_mat[k][i] = 16'($urandom);
            for (int j = 0; j < W; j++) b_mat[k][j] = 16'($urandom);
        end
    endtask

    task automatic run_job(input string name, input int k_req, input bit mode,
                           input bit bubble_alt, input bit bubble_rand,
                           input int bp, input bit poke_start);
        int  keff;
        int  idx;
        int  cyc;
        bit  v;
        bit  rdy;
        keff = (k_req > KMAX) ? KMAX : k_req;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) exp_c[i][j] = model_c(i, j, keff, mode);

        start = 1'b1;
        k_len = KW'(k_req);
        signed_mode = mode;
        tick();
        start = 1'b0;
        check_value({name, " busy_after_start"}, 64'(busy), 64'd1);

        idx = 0;
        cyc = 0;
        while (idx < keff && cyc < keff*4 + 40) begin
            if (bubble_alt)       v = (cyc % 2 == 0);
            else if (bubble_rand) v = bit'($urandom_range(0, 1));
            else                  v = 1'b1;
            check_value({name, " busy_load"}, 64'(busy), 64'd1);
            check_value({name, " in_ready_load"}, 64'(in_ready), 64'd1);
            if (poke_start && cyc == 1) begin
                start = 1'b1;
                k_len = KW'(7);
                signed_mode = ~mode;
            end else begin
                start = 1'b0;
                signed_mode = mode;
            end
            in_valid = v;
            for (int i = 0; i < H; i++) in_a[i*DW +: DW] = v ? a_mat[idx][i] : 16'($urandom);
            for (int j = 0; j < W; j++) in_b[j*DW +: DW] = v ? b_mat[idx][j] : 16'($urandom);
            rdy = in_ready;
            tick();
            if (v && rdy) idx++;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        in_a = '1;
        in_b = '1;
        if (idx < keff) check_value({name, " load_timeout"}, 64'(idx), 64'(keff));
        if (keff > 0) check_value({name, " in_ready_after_load"}, 64'(in_ready), 64'd0);

        cyc = 0;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        check_value({name, " drain_reached"}, 64'(out_valid), 64'd1);
        if (!out_valid) return;

        for (int r = 0; r < H; r++) begin
            if (r == 0) begin
                for (int s = 0; s < bp; s++) begin
                    out_ready = 1'b0;
                    check_value({name, " stall_valid"}, 64'(out_valid), 64'd1);
                    check_value({name, " stall_idx"}, 64'(out_row_idx), 64'd0);
                    check_value({name, " stall_lane0"}, 64'(out_row[0 +: AW]), 64'(exp_c[0][0]));
                    check_value({name, " stall_lane3"}, 64'(out_row[(W-1)*AW +: AW]), 64'(exp_c[0][W-1]));
                    tick();
                end
            end
            check_value($sformatf("%s r%0d valid", name, r), 64'(out_valid), 64'd1);
            check_value($sformatf("%s r%0d idx", name, r), 64'(out_row_idx), 64'(r));
            check_value($sformatf("%s r%0d last", name, r), 64'(out_last), 64'(r == H-1));
            for (int j = 0; j < W; j++)
                check_value($sformatf("%s r%0d c%0d", name, r, j), 64'(out_row[j*AW +: AW]), 64'(exp_c[r][j]));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check_value({name, " done_pulse"}, 64'(done), 64'd1);
        check_value({name, " busy_at_done"}, 64'(busy), 64'd0);
        check_value({name, " valid_at_done"}, 64'(out_valid), 64'd0);
        start = 1'b1;
        k_len = KW'(5);
        tick();
        start = 1'b0;
        check_value({name, " done_cleared"}, 64'(done), 64'd0);
        check_value({name, " start_in_done_ignored"}, 64'(busy), 64'd0);
        $display("job %s k=%0d mode=%0d complete", name, k_req, mode);
    endtask

    initial begin
        repeat (3) tick();
        check_value("reset busy", 64'(busy), 64'd0);
        check_value("reset done", 64'(done), 64'd0);
        check_value("reset in_ready", 64'(in_ready), 64'd0);
        check_value("reset out_valid", 64'(out_valid), 64'd0);
        check_value("reset out_last", 64'(out_last), 64'd0);
        check_value("reset out_row", 64'(out_row[0 +: AW]), 64'd0);
        reset = 1'b1;
        tick();

        fill_identity();
        run_job("identity", 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_job("bubbles", 4, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_job("backpressure", 4, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_job("start_poke", 4, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        fill_const(16'hFFFF, 16'd2);
        run_job("sign_s", 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_job("sign_u", 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        fill_random();
        run_job("k_zero", 0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        run_job("k_clamp", 300, 1'b1, 1'b0, 1'b1, 1, 1'b0);

        // Abort a job after two vectors and confirm nothing survives.
        fill_identity();
        start = 1'b1;
        k_len = KW'(4);
        signed_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < H; i++) in_a[i*DW +: DW] = a_mat[k][i];
            for (int j = 0; j < W; j++) in_b[j*DW +: DW] = b_mat[k][j];
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_value("midreset busy", 64'(busy), 64'd0);
        check_value("midreset in_ready", 64'(in_ready), 64'd0);
        check_value("midreset out_valid", 64'(out_valid), 64'd0);
        check_value("midreset done", 64'(done), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_job("after_reset", 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_job($sformatf("rand%0d", n), int'($urandom_range(1, 24)), bit'($urandom_range(0, 1)),
                    1'b0, 1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_gemm_tile.md
Name: systolic_gemm_tile

Overview:
- Output-stationary ARR_HEIGHT x ARR_WIDTH MAC array with built-in input skew, K-length job control, flush and row-serial result drain.
- Successor to the bare PE grid: upstream supplies unskewed A-column/B-row vectors with a valid/ready handshake; downstream receives accumulated C rows with a valid/ready handshake.
- Sits between the operand buffers and the result writeback in the MoE compute path.

Parameters:
- WIDTH, 16, operand width in bits.
- ARR_HEIGHT, 4, array rows (number of A lanes, number of C rows).
- ARR_WIDTH, 4, array columns (number of B lanes, C elements per row).
- ACC_W, 40, accumulator width in bits; must be at least 2*WIDTH.
- K_MAX, 256, maximum reduction length; KW = $clog2(K_MAX+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launches a job when the block is idle.
- k_len  in  KW  reduction length, sampled on start.
- signed_mode  in  1  1 = signed operands, 0 = unsigned; sampled on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last row is accepted.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block accepts an operand vector.
- in_a  in  ARR_HEIGHT*WIDTH  A column k; lane i drives row i.
- in_b  in  ARR_WIDTH*WIDTH  B row k; lane j drives column j.
- out_valid  out  1  C row valid.
- out_ready  in  1  downstream accepts the C row.
- out_row  out  ARR_WIDTH*ACC_W  C row; lane j = C[idx][j].
- out_row_idx  out  $clog2(ARR_HEIGHT) (min 1)  index of the row on out_row.
- out_last  out  1  high with row ARR_HEIGHT-1.

Behaviour:
- Reset: all outputs 0, state IDLE; accumulators, skew registers and PE pipeline registers cleared.
- FSM states: IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE: start=1 latches k_len, clamped to K_MAX, and latches signed_mode; clears all accumulators; sets busy.
  - Next state is LOAD, or DRAIN if k_len=0.
  - start in any other state is ignored.
- LOAD: in_ready=1.
  - Array step occurs only on in_valid&in_ready; k counter increments on each step.
  - When in_valid=0, all skew/PE/accumulator registers hold (global enable).
  - After the k_len-th accepted vector, go to FLUSH.
- Skew: row i operand delayed i steps; column j operand delayed j steps.
  - A passes east and B passes south one PE per step.
  - Zeros are injected into the skew inputs whenever not in LOAD.
- FLUSH: in_ready=0; steps every cycle for exactly ARR_HEIGHT+ARR_WIDTH-1 cycles, then go to DRAIN.
- Result: C[i][j] = sum over k<k_len of A[k][i]*B[k][j].
  - Products are sign- or zero-extended to ACC_W per signed_mode.
  - Accumulation wraps modulo 2^ACC_W.
- DRAIN: out_valid=1 and out_row = row r, starting at r=0.
  - On out_valid&out_ready, r increments.
  - While out_ready=0, out_row, out_row_idx and out_last are held stable.
  - Handshake on r=ARR_HEIGHT-1 (out_last=1) moves to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, out_valid=0; go to IDLE.
  - A start in this cycle is ignored.
- Reset asserted mid-job aborts immediately with reset values; no partial output.

Optional Feature:
- SA_SATURATE_EN defined: each accumulate saturates instead of wrapping.
  - signed_mode=1: clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - signed_mode=0: clamps to [0, 2^ACC_W-1].
- SA_SATURATE_EN undefined: modulo-2^ACC_W wrap; no saturation logic is synthesised.

Test Plan:
- Identity: k_len=4, A=I (A[k][i]=1 if i==k), B[k][j]=4k+j+1, in_valid always 1, out_ready 1 -> rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, out_last on row 3, then done pulse.
- Bubbles: same job with in_valid low on alternate cycles -> identical rows; in_ready=1 only in LOAD; busy stays high throughout.
- Backpressure: out_ready=0 for 5 cycles at row 0, then 1 -> out_valid held, out_row={1,2,3,4} stable, out_row_idx=0; done 1 cycle after the row-3 handshake.
- Sign: all A=16'hFFFF, all B=2, k_len=3.
  - signed_mode=1 -> every C=-6.
  - signed_mode=0 -> every C=393210.
- Edges: k_len=0 -> four zero rows, then done.
  - Also: start pulsed while busy -> no effect on the result.
  - Also: k_len=300 -> treated as 256.
- Reset mid-LOAD after 2 vectors: reset low -> busy, in_ready, out_valid, done all 0.
  - Next Identity job -> exact Identity results, no residue.
